exec_alu: RTL and testbench
===========================

EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; only 16 is required to be supported.
REQ-002 Parameter: ITER, WIDTH, iteration count of the MUL/DIV engines.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request; sampled only while the unit is not busy.
REQ-006 op_select  in  3  operation code from the upstream decoder.
REQ-007 sub  in  1  subtract qualifier, used only for op_select=000.
REQ-008 a, b  in  WIDTH  operands; a is the dividend, b is the divisor.
REQ-009 busy  out  1  high while a MUL/DIV iteration is in progress.
REQ-010 done  out  1  one-cycle pulse; result and flags are valid in this cycle.
REQ-011 result  out  WIDTH  registered result, held until the next done.
REQ-012 remainder  out  WIDTH  DIV remainder; 0 after any non-DIV operation.
REQ-013 flags  out  5  {err, dz, ovf, carry, zero}, registered with result.

Function
REQ-014 Operations (op_select): 000 ADD (sub=0) or SUB (sub=1); 010 AND; 011 OR; 100 MUL; 101 DIV.
REQ-015 Illegal codes 001, 110, 111: result=0, err=1, all other flags 0, completing with single-cycle latency.
REQ-016 Accept: start=1 while state IDLE (including the done cycle of the previous op); operands and op are captured at this edge (cycle N).
REQ-017 Single-cycle ops (ADD/SUB/AND/OR/illegal): done=1 and result valid in cycle N+1; busy stays 0.
REQ-018 MUL/DIV: busy=1 in cycles N+1..N+ITER; done=1 and busy=0 in cycle N+ITER+1.
REQ-019 start while busy is ignored, with no queuing and no effect on the operation in flight.
REQ-020 FSM states: IDLE, MUL, DIV.
REQ-021 FSM transitions: IDLE->MUL or DIV on an accepted 100/101; MUL/DIV->IDLE after ITER iterations; all other accepts remain in IDLE.
REQ-022 ADD/SUB: result = a+b or a+~b+1 modulo 2^WIDTH; carry = carry-out of that sum (SUB: 1 means no borrow).
REQ-023 MUL: unsigned shift-add, one partial product per cycle; result = low WIDTH bits; ovf=1 iff the high WIDTH bits are nonzero.
REQ-024 DIV: unsigned restoring division, one quotient bit per cycle; result = quotient; remainder = remainder.
REQ-025 DIV by zero: still takes ITER cycles; result=all ones; remainder=a; dz=1.
REQ-026 zero=1 iff result==0, for every op.
REQ-027 carry, ovf, dz and err are 0 for every op that does not define them.
REQ-028 Operand inputs are don't-care after the accept cycle; internal copies are used throughout.

Reset
REQ-029 rst=1 forces immediately: state IDLE, busy=0, done=0, result=0, remainder=0, flags=0, iteration counter=0.
REQ-030 rst asserted mid-MUL/DIV aborts the operation: no done is produced for it.
REQ-031 After rst deasserts, the first rising edge with start=1 is accepted.

Structure
REQ-032 Shared package alu_pkg holds: opcode localparams (OP_ADD=000, OP_AND=010, OP_OR=011, OP_MUL=100, OP_DIV=101), the FSM state encoding, the flag bit indices and the WIDTH default.
REQ-033 The upstream decoder and exec_alu both use alu_pkg opcodes.
REQ-034 One sub-module: shift_sub_divider (iterative restoring divider with its own counter and start/done handshake); the multiplier stays inline.

Verification
REQ-035 ADD a=0x7FFF, b=0x0001, sub=0 -> result 0x8000, carry=0, zero=0, done at N+1, busy never high.
REQ-036 SUB a=0x0005, b=0x0007 -> result 0xFFFE, carry=0; then SUB 7-5 -> result 0x0002, carry=1.
REQ-037 MUL a=0x0100, b=0x0100 -> result 0x0000, ovf=1, zero=1, busy N+1..N+16, done at N+17.
REQ-038 DIV a=100, b=7 -> result 14, remainder 2; a start with ADD at N+3 is ignored; a new start in the done cycle is accepted.
REQ-039 DIV a=0x1234, b=0 -> result 0xFFFF, remainder 0x1234, dz=1, done at N+17.
REQ-040 MUL started, rst pulsed at N+5 -> all outputs 0 immediately, no done follows; AND 0xF0F0&0x0FF0 after reset -> result 0x00F0 at N'+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag layout shared by the decoder and exec_alu.
package alu_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 2;
  localparam int F_DZ    = 3;
  localparam int F_ERR   = 4;
  function automatic logic [4:0] mk_flags(input logic err, dz, ovf, carry, zero);
    mk_flags = '0;
    mk_flags[F_ERR] = err;
    mk_flags[F_DZ] = dz;
    mk_flags[F_OVF] = ovf;
    mk_flags[F_CARRY] = carry;
    mk_flags[F_ZERO] = zero;
  endfunction
endpackage

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: unsigned restoring divider, one quotient bit per cycle.
module shift_sub_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(ITER + 1);
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dsr;
  logic [WIDTH:0]   shifted, diff;
  // quotient/remainder present the post-step values so the caller can latch them on the done cycle
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dsr};
    quotient = {quo[WIDTH-2:0], ~diff[WIDTH]};
    remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    done = busy && cnt == CW'(ITER - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt <= '0;
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (busy) begin
      quo <= quotient;
      rem <= remainder;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
endmodule

// File: rtl/exec_alu.sv
// exec_alu: single-cycle ADD/SUB/AND/OR plus iterative MUL (inline) and DIV (sub-module).
module exec_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_select,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [4:0]       flags
);
  localparam int CW = $clog2(ITER + 1);
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand, acc_next;
  logic [WIDTH-1:0]   mplier, r1, quo, rem;
  logic [WIDTH:0]     sum;
  logic [4:0]         f1;
  logic               accept, is_add, legal, dz, div_done;
  always_comb begin
    accept = start && state == IDLE;
    is_add = op_select == OP_ADD;
    legal = is_add || op_select == OP_AND || op_select == OP_OR;
    sum = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, sub};
    r1 = is_add ? sum[WIDTH-1:0] : op_select == OP_AND ? a & b : op_select == OP_OR ? a | b : '0;
    f1 = mk_flags(!legal, 1'b0, 1'b0, is_add && sum[WIDTH], legal && r1 == '0);
    acc_next = acc + (mplier[0] ? mcand : '0);
  end
  shift_sub_divider #(.WIDTH(WIDTH), .ITER(ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && op_select == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      remainder <= '0;
      flags <= '0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      dz <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && op_select == OP_MUL) begin
        state <= MUL;
        busy <= 1'b1;
        cnt <= '0;
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, a};
        mplier <= b;
      end else if (accept && op_select == OP_DIV) begin
        state <= DIV;
        busy <= 1'b1;
        dz <= b == '0;
      end else if (accept) begin
        done <= 1'b1;
        result <= r1;
        remainder <= '0;
        flags <= f1;
      end else if (state == MUL) begin
        acc <= acc_next;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(ITER - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          cnt <= '0;
          result <= acc_next[WIDTH-1:0];
          remainder <= '0;
          flags <= mk_flags(1'b0, 1'b0, |acc_next[2*WIDTH-1:WIDTH], 1'b0, acc_next[WIDTH-1:0] == '0);
        end
      end else if (state == DIV && div_done) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
        result <= quo;
        remainder <= rem;
        flags <= mk_flags(1'b0, dz, 1'b0, 1'b0, quo == '0);
      end
    end
endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed vectors with hand-computed results for exec_alu.
module tb_exec_alu;
  logic        clk, rst, start, sub, busy, done;
  logic [2:0]  op_select;
  logic [15:0] a, b, result, remainder;
  logic [4:0]  flags;
  int checks = 0;
  int errors = 0;

  exec_alu #(.WIDTH(16), .ITER(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_select (op_select),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic s, input logic [15:0] x, input logic [15:0] y);
    op_select = op;
    sub = s;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [15:0] res, input logic [15:0] rem,
                             input logic [4:0] flg);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(res));
    chk({tag, "_rem"}, 32'(remainder), 32'(rem));
    chk({tag, "_flags"}, 32'(flags), 32'(flg));
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start = 1'b0;
    op_select = 3'b000;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) tick();
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    issue(3'b000, 1'b0, 16'h7FFF, 16'h0001);
    expect_done("add", 16'h8000, 16'h0000, 5'b00000);
    tick();
    chk("add_pulse", 32'(done), 32'd0);
    chk("add_nobusy", 32'(busy), 32'd0);

    issue(3'b000, 1'b1, 16'h0005, 16'h0007);
    expect_done("sub57", 16'hFFFE, 16'h0000, 5'b00000);
    issue(3'b000, 1'b1, 16'h0007, 16'h0005);
    expect_done("sub75", 16'h0002, 16'h0000, 5'b00010);
    issue(3'b000, 1'b0, 16'hFFFF, 16'h0001);
    expect_done("addwrap", 16'h0000, 16'h0000, 5'b00011);
    issue(3'b011, 1'b0, 16'hF000, 16'h000F);
    expect_done("or", 16'hF00F, 16'h0000, 5'b00000);
    issue(3'b110, 1'b0, 16'h1234, 16'h5678);
    expect_done("ill110", 16'h0000, 16'h0000, 5'b10000);
    issue(3'b001, 1'b1, 16'h0001, 16'h0001);
    expect_done("ill001", 16'h0000, 16'h0000, 5'b10000);

    issue(3'b100, 1'b0, 16'h0100, 16'h0100);
    a = 16'hDEAD;
    b = 16'hBEEF;
    for (int c = 1; c <= 16; c++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_early_done", 32'(done), 32'd0);
      tick();
    end
    expect_done("mul_ovf", 16'h0000, 16'h0000, 5'b00101);

    issue(3'b100, 1'b0, 16'd300, 16'd200);
    wait_done("mul2", 17);
    expect_done("mul2", 16'hEA60, 16'h0000, 5'b00000);

    issue(3'b101, 1'b0, 16'd100, 16'd7);
    for (int c = 1; c <= 16; c++) begin
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_early_done", 32'(done), 32'd0);
      start = (c == 3);
      if (c == 3) begin
        op_select = 3'b000;
        sub = 1'b0;
        a = 16'h0001;
        b = 16'h0001;
      end
      tick();
      start = 1'b0;
    end
    expect_done("div", 16'd14, 16'd2, 5'b00000);
    issue(3'b010, 1'b0, 16'hFF00, 16'h0F0F);
    expect_done("and_in_done", 16'h0F00, 16'h0000, 5'b00000);

    issue(3'b101, 1'b0, 16'h0000, 16'h0005);
    wait_done("div0n", 17);
    expect_done("div0n", 16'h0000, 16'h0000, 5'b00001);
    issue(3'b101, 1'b0, 16'h1234, 16'h0000);
    wait_done("divz", 17);
    expect_done("divz", 16'hFFFF, 16'h1234, 5'b01000);

    issue(3'b100, 1'b0, 16'h0003, 16'h0003);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    repeat (24) begin
      tick();
      if (done || busy) nd++;
    end
    chk("abort_quiet", 32'(nd), 32'd0);
    issue(3'b010, 1'b0, 16'hF0F0, 16'h0FF0);
    expect_done("and_post_rst", 16'h00F0, 16'h0000, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
